// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calc_sequencer
// Description : Front-end controller for the four-mode switch calculator.
//               Debounces KEY[0] (go) and KEY[1] (mode), cycles MODE, latches
//               the switch operands, issues a one-cycle START to the datapath,
//               waits for DONE with a timeout and holds the result for display.
// Options     : CALC_SEQ_AUTOCYCLE_EN - when defined, IDLE auto-advances MODE
//               and relaunches the held operation every HOLD_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RESET,
    input  logic [1:0] KEY,
    input  logic [9:0] SW,
    output logic [1:0] MODE,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic [1:0] OPERATION,
    output logic       START,
    input  logic       DONE,
    input  logic [7:0] RESULT,
    output logic [7:0] DISP,
    output logic       BUSY,
    output logic       ERROR
);

    localparam int c_DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        c_ERR_CODE = 8'hEE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         w_press;
    logic               w_go;
    logic               w_mode;
    logic               w_latch;
    logic               w_mode_inc;
    logic               w_done_ok;
    logic               w_timeout;
    logic               w_auto_fire;
    logic [1:0]         r_mode;
    logic [3:0]         r_x;
    logic [3:0]         r_y;
    logic [1:0]         r_op;
    logic [7:0]         r_disp;
    logic               r_error;
    logic [c_TO_W-1:0]  r_wait_cnt;

    // Per-key synchronizer and debouncer; a press is a debounced 1->0 edge.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic              r_meta;
            logic              r_sync;
            logic              r_level;
            logic              r_pulse;
            logic [c_DB_W-1:0] r_cnt;

            // Two-stage synchronizer; resets to the released (high) level.
            always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
                if (RESET) begin
                    r_meta <= 1'b1;
                    r_sync <= 1'b1;
                end else begin
                    r_meta <= KEY[gi];
                    r_sync <= r_meta;
                end
            end

            // Accept a new level only after DEBOUNCE_CYCLES consecutive cycles at it.
            always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
                if (RESET) begin
                    r_level <= 1'b1;
                    r_cnt   <= '0;
                    r_pulse <= 1'b0;
                end else begin
                    r_pulse <= 1'b0;
                    if (r_sync == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_level <= r_sync;
                        r_cnt   <= '0;
                        r_pulse <= ~r_sync;
                    end else begin
                        r_cnt <= r_cnt + c_DB_W'(1);
                    end
                end
            end

            assign w_press[gi] = r_pulse;
        end
    endgenerate

    assign w_go   = w_press[0];
    assign w_mode = w_press[1];

    // State register.
    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control strobes; presses outside IDLE are simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_mode_inc  = 1'b0;
        w_done_ok   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mode_inc = w_mode;
                if (w_go) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_EXEC;
                end else if (w_auto_fire) begin
                    w_mode_inc  = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // DONE takes priority over an expiry in the same cycle.
                if (DONE) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wait_cnt == c_TO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Mode, operand, timeout counter and held-result registers.
    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
        if (RESET) begin
            r_mode     <= 2'd0;
            r_x        <= 4'd0;
            r_y        <= 4'd0;
            r_op       <= 2'd0;
            r_disp     <= 8'd0;
            r_error    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (w_mode_inc) begin
                r_mode <= r_mode + 2'd1;
            end
            if (w_latch) begin
                r_x  <= SW[3:0];
                r_y  <= SW[7:4];
                r_op <= SW[9:8];
            end
            if (r_state == S_EXEC) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + c_TO_W'(1);
            end
            if (w_done_ok) begin
                r_disp  <= RESULT;
                r_error <= 1'b0;
            end else if (w_timeout) begin
                r_disp  <= c_ERR_CODE;
                r_error <= 1'b1;
            end
        end
    end

`ifdef CALC_SEQ_AUTOCYCLE_EN
    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);

    logic                r_have_result;
    logic [c_HOLD_W-1:0] r_dwell;

    // Dwell counter runs only in IDLE after a good result; any press restarts it.
    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
        if (RESET) begin
            r_have_result <= 1'b0;
            r_dwell       <= '0;
        end else begin
            if (w_done_ok) begin
                r_have_result <= 1'b1;
            end
            if ((r_state != S_IDLE) || (|w_press) || !r_have_result || r_error) begin
                r_dwell <= '0;
            end else if (r_dwell != c_HOLD_LAST) begin
                r_dwell <= r_dwell + c_HOLD_W'(1);
            end
        end
    end

    assign w_auto_fire = r_have_result & ~r_error & ~(|w_press) & (r_dwell == c_HOLD_LAST);
`else
    logic w_unused_hold;
    assign w_unused_hold = (HOLD_CYCLES != 0);
    assign w_auto_fire   = 1'b0;
`endif

    assign MODE      = r_mode;
    assign X         = r_x;
    assign Y         = r_y;
    assign OPERATION = r_op;
    assign DISP      = r_disp;
    assign ERROR     = r_error;
    assign START     = (r_state == S_EXEC);
    assign BUSY      = (r_state != S_IDLE);

endmodule
`default_nettype wire
